// File: rtl/score_table_responder_if.sv
// Score hand-off bus between the game controller (master) and the
// high-score table responder (slave); state_dbg exposes the responder FSM.
interface score_table_responder_if #(
    parameter int SCORE_W = 32,
    parameter int ACK_W   = 32
);
    // Four-phase handshake: the master holds NEW_SCORE_EN=1 with a nonzero
    // NEW_SCORE; the slave raises ACK[0] once the score is in the table and
    // drops it on the first edge where the master has withdrawn the offer
    // (EN=0 or score=0). A new offer is only taken after ACK[0] is low again.
    logic [SCORE_W-1:0] NEW_SCORE;
    logic               NEW_SCORE_EN;
    logic               clr;
    logic [SCORE_W-1:0] first;
    logic [SCORE_W-1:0] second;
    logic [SCORE_W-1:0] third;
    logic [SCORE_W-1:0] fourth;
    logic [SCORE_W-1:0] fifth;
    logic [ACK_W-1:0]   ACK;
    logic               busy;
    logic [2:0]         rank;
    logic [1:0]         state_dbg;

    modport master (
        output NEW_SCORE, NEW_SCORE_EN, clr,
        input  first, second, third, fourth, fifth, ACK, busy, rank, state_dbg
    );

    modport slave (
        input  NEW_SCORE, NEW_SCORE_EN, clr,
        output first, second, third, fourth, fifth, ACK, busy, rank, state_dbg
    );
endinterface

// File: rtl/score_table_responder.sv
// Top-5 high-score table with fixed-latency sequential insertion sort and a
// four-phase ACK handshake. Optional macro: SCORE_TABLE_DEDUP_EN (skip duplicates).
module score_table_responder #(
    parameter int SCORE_W = 32,
    parameter int ACK_W   = 32
) (
    input  logic                    iVGA_CLK,
    input  logic                    iRST_n,
    score_table_responder_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INSERT   = 2'd1,
        ACK_HOLD = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SCORE_W-1:0] r_entry [5];
    logic [SCORE_W-1:0] w_entry_nxt [5];
    logic [SCORE_W-1:0] r_cand;
    logic [SCORE_W-1:0] w_cand_nxt;
    logic [2:0]         r_idx;
    logic [2:0]         w_idx_nxt;
    logic [2:0]         r_rank;
    logic [2:0]         w_rank_nxt;
    logic               r_ack;
    logic               r_busy;
    logic               w_offer;
    logic               w_release;

    assign w_offer   = bus.NEW_SCORE_EN && (bus.NEW_SCORE != '0);
    assign w_release = !w_offer;

`ifdef SCORE_TABLE_DEDUP_EN
    logic w_dup;
    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (r_entry[i] == r_cand) w_dup = 1'b1;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_idx_nxt   = r_idx;
        w_rank_nxt  = r_rank;
        for (int i = 0; i < 5; i++) w_entry_nxt[i] = r_entry[i];

        case (r_state)
            IDLE: begin
                if (bus.clr) begin
                    for (int i = 0; i < 5; i++) w_entry_nxt[i] = '0;
                    w_rank_nxt = 3'd0;
                end else if (w_offer) begin
                    w_cand_nxt  = bus.NEW_SCORE;
                    w_idx_nxt   = 3'd0;
                    w_rank_nxt  = 3'd0;
                    w_state_nxt = INSERT;
                end
            end
            INSERT: begin
`ifdef SCORE_TABLE_DEDUP_EN
                if ((r_idx == 3'd0) && w_dup) begin
                    w_rank_nxt  = 3'd0;
                    w_state_nxt = ACK_HOLD;
                end else
`endif
                begin
                    // rank is still 0 until the first swap, so it marks the landing slot
                    for (int i = 0; i < 5; i++) begin
                        if ((r_idx == 3'(i)) && (r_cand > r_entry[i])) begin
                            w_entry_nxt[i] = r_cand;
                            w_cand_nxt     = r_entry[i];
                            if (r_rank == 3'd0) w_rank_nxt = 3'(i + 1);
                        end
                    end
                    if (r_idx == 3'd4) w_state_nxt = ACK_HOLD;
                    else               w_idx_nxt   = r_idx + 3'd1;
                end
            end
            ACK_HOLD: begin
                if (w_release) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state <= IDLE;
            r_cand  <= '0;
            r_idx   <= 3'd0;
            r_rank  <= 3'd0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            for (int i = 0; i < 5; i++) r_entry[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_idx   <= w_idx_nxt;
            r_rank  <= w_rank_nxt;
            r_ack   <= (w_state_nxt == ACK_HOLD);
            r_busy  <= (w_state_nxt != IDLE);
            for (int i = 0; i < 5; i++) r_entry[i] <= w_entry_nxt[i];
        end
    end

    assign bus.first     = r_entry[0];
    assign bus.second    = r_entry[1];
    assign bus.third     = r_entry[2];
    assign bus.fourth    = r_entry[3];
    assign bus.fifth     = r_entry[4];
    assign bus.ACK       = {{(ACK_W-1){1'b0}}, r_ack};
    assign bus.busy      = r_busy;
    assign bus.rank      = r_rank;
    assign bus.state_dbg = r_state;
endmodule

// File: tb/tb_score_table_responder.sv
// Self-checking bench for score_table_responder: directed scenarios plus
// randomized offers scored against a sorted-queue model of the top-5 table.
module tb_score_table_responder;
  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] act [5];

  score_table_responder_if #(.SCORE_W(W), .ACK_W(32)) bus ();

  score_table_responder #(.SCORE_W(W), .ACK_W(32)) dut (
    .iVGA_CLK (clk),
    .iRST_n   (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    act[0] = bus.first;
    act[1] = bus.second;
    act[2] = bus.third;
    act[3] = bus.fourth;
    act[4] = bus.fifth;
  end

  task automatic model_clear();
    exp_q = '{};
    for (int i = 0; i < 5; i++) exp_q.push_back('0);
  endtask

  // The score lands below every entry >= it; returns rank and ACK delay in edges.
  task automatic model_insert(input logic [W-1:0] s, output int rank, output int lat);
    int pos;
    bit dup;
    pos = 0;
    dup = 0;
    foreach (exp_q[i]) begin
      if (exp_q[i] >= s) pos++;
      if (exp_q[i] == s) dup = 1;
    end
    lat = 5;
`ifdef SCORE_TABLE_DEDUP_EN
    if (dup) begin
      rank = 0;
      lat = 1;
      return;
    end
`endif
    if (pos < 5) begin
      exp_q.insert(pos, s);
      void'(exp_q.pop_back());
      rank = pos + 1;
    end else begin
      rank = 0;
    end
  endtask

  task automatic do_offer(input logic [W-1:0] s, input int hold);
    int exp_rank;
    int exp_lat;
    int n;
    model_insert(s, exp_rank, exp_lat);
    @(negedge clk);
    bus.NEW_SCORE = s;
    bus.NEW_SCORE_EN = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_errors++;
      $display("FAIL accept_busy score=%0d got=%b want=1", s, bus.busy);
    end
    n = 0;
    while (bus.ACK[0] !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (n !== exp_lat) begin
      n_errors++;
      $display("FAIL ack_latency score=%0d got=%0d want=%0d", s, n, exp_lat);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (act[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL table[%0d] score=%0d got=%0d want=%0d", i, s, act[i], exp_q[i]);
      end
    end
    n_checks++;
    if (bus.rank !== 3'(exp_rank)) begin
      n_errors++;
      $display("FAIL rank score=%0d got=%0d want=%0d", s, bus.rank, exp_rank);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.ACK !== 32'd1 || bus.busy !== 1'b1 || act[0] !== exp_q[0] || act[4] !== exp_q[4]) begin
        n_errors++;
        $display("FAIL ack_hold cyc=%0d ack=%0d busy=%b first=%0d want ack=1 busy=1 first=%0d",
                 h, bus.ACK, bus.busy, act[0], exp_q[0]);
      end
    end
    @(negedge clk);
    if ($urandom_range(0, 1) == 0) bus.NEW_SCORE = '0;
    else                           bus.NEW_SCORE_EN = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.ACK !== 32'd0 || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL ack_release got ack=%0d busy=%b want 0/0", bus.ACK, bus.busy);
    end
    @(negedge clk);
    bus.NEW_SCORE = '0;
    bus.NEW_SCORE_EN = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus.clr = 1'b1;
    @(posedge clk); #1;
    model_clear();
    n_checks++;
    if (act[0] !== '0 || act[1] !== '0 || act[2] !== '0 || act[3] !== '0 || act[4] !== '0 ||
        bus.rank !== 3'd0 || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL clear got first=%0d fifth=%0d rank=%0d busy=%b want all 0",
               act[0], act[4], bus.rank, bus.busy);
    end
    @(negedge clk);
    bus.clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.NEW_SCORE = '0;
    bus.NEW_SCORE_EN = 1'b0;
    bus.clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (act[0] !== '0 || act[1] !== '0 || act[2] !== '0 || act[3] !== '0 || act[4] !== '0 ||
        bus.ACK !== 32'd0 || bus.rank !== 3'd0 || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state first=%0d ack=%0d rank=%0d busy=%b want all 0",
               act[0], bus.ACK, bus.rank, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_first_score();
    do_offer(32'd100, 0);
    n_checks++;
    if (bus.first !== 32'd100 || bus.second !== 32'd0) begin
      n_errors++;
      $display("FAIL first_score got first=%0d second=%0d want 100/0", bus.first, bus.second);
    end
  endtask

  task automatic test_sequence();
    logic [W-1:0] seq [6];
    seq = '{32'd50, 32'd300, 32'd200, 32'd10, 32'd400, 32'd250};
    for (int i = 0; i < 6; i++) do_offer(seq[i], $urandom_range(0, 2));
    n_checks++;
    if (bus.first !== 32'd400 || bus.second !== 32'd300 || bus.third !== 32'd250 ||
        bus.fourth !== 32'd200 || bus.fifth !== 32'd100 || bus.rank !== 3'd3) begin
      n_errors++;
      $display("FAIL sequence_table got %0d,%0d,%0d,%0d,%0d rank=%0d want 400,300,250,200,100 rank=3",
               bus.first, bus.second, bus.third, bus.fourth, bus.fifth, bus.rank);
    end
  endtask

  task automatic test_low_score();
    do_offer(32'd5, 1);
    n_checks++;
    if (bus.fifth !== 32'd100 || bus.rank !== 3'd0) begin
      n_errors++;
      $display("FAIL low_score got fifth=%0d rank=%0d want 100/0", bus.fifth, bus.rank);
    end
  endtask

  task automatic test_tie();
    do_offer(32'd300, 0);
    n_checks++;
`ifdef SCORE_TABLE_DEDUP_EN
    if (bus.third !== 32'd250 || bus.fifth !== 32'd100 || bus.rank !== 3'd0) begin
      n_errors++;
      $display("FAIL tie_dedup got third=%0d fifth=%0d rank=%0d want 250/100/0",
               bus.third, bus.fifth, bus.rank);
    end
`else
    if (bus.second !== 32'd300 || bus.third !== 32'd300 || bus.fourth !== 32'd250 ||
        bus.fifth !== 32'd200 || bus.rank !== 3'd3) begin
      n_errors++;
      $display("FAIL tie got %0d,%0d,%0d,%0d rank=%0d want 300,300,250,200 rank=3",
               bus.second, bus.third, bus.fourth, bus.fifth, bus.rank);
    end
`endif
  endtask

  task automatic test_hold_no_reinsert();
    do_clear();
    do_offer(32'd77, 20);
    n_checks++;
    if (bus.first !== 32'd77 || bus.second !== 32'd0) begin
      n_errors++;
      $display("FAIL hold_single got first=%0d second=%0d want 77/0", bus.first, bus.second);
    end
  endtask

  task automatic test_clr_priority();
    int n;
    @(negedge clk);
    bus.clr = 1'b1;
    bus.NEW_SCORE = 32'd9;
    bus.NEW_SCORE_EN = 1'b1;
    @(posedge clk); #1;
    model_clear();
    n_checks++;
    if (bus.first !== 32'd0 || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL clr_priority got first=%0d busy=%b want 0/0", bus.first, bus.busy);
    end
    bus.clr = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_errors++;
      $display("FAIL clr_then_accept busy got=%b want=1", bus.busy);
    end
    n = 0;
    while (bus.ACK[0] !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (n !== 5 || bus.first !== 32'd9 || bus.rank !== 3'd1) begin
      n_errors++;
      $display("FAIL clr_then_insert latency=%0d first=%0d rank=%0d want 5/9/1", n, bus.first, bus.rank);
    end
    exp_q[0] = 32'd9;
    @(negedge clk);
    bus.NEW_SCORE_EN = 1'b0;
    bus.NEW_SCORE = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_insert();
    @(negedge clk);
    bus.NEW_SCORE = 32'd500;
    bus.NEW_SCORE_EN = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    bus.NEW_SCORE_EN = 1'b0;
    bus.NEW_SCORE = '0;
    #1;
    n_checks++;
    if (act[0] !== '0 || act[4] !== '0 || bus.ACK !== 32'd0 || bus.rank !== 3'd0 || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset got first=%0d fifth=%0d ack=%0d rank=%0d busy=%b want all 0",
               act[0], act[4], bus.ACK, bus.rank, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    do_offer(32'd1, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 7) == 0) do_clear();
      else if ($urandom_range(0, 3) == 0) do_offer($urandom(), $urandom_range(0, 3));
      else do_offer(32'($urandom_range(1, 40)), $urandom_range(0, 3));
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_first_score();
    test_sequence();
    test_low_score();
    test_tie();
    test_hold_no_reinsert();
    test_clr_priority();
    test_reset_mid_insert();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
